// File: rtl/rsa_avm_pkg.sv
// Shared definitions for the UART Avalon-MM arbiter: register map,
// STATUS bit positions, arbiter state encoding and requester ID type.
package rsa_avm_pkg;

    // UART register addresses as seen on avm_address
    localparam logic [4:0] RX_ADDR     = 5'd0;
    localparam logic [4:0] TX_ADDR     = 5'd4;
    localparam logic [4:0] STATUS_ADDR = 5'd8;

    // STATUS register bit indices
    localparam int RRDY = 7;
    localparam int TRDY = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // 0 = read pipeline, 1 = write pipeline
    typedef logic req_id_t;

    // Grant state that corresponds to a requester ID
    function automatic arb_state_t gnt_state(input req_id_t id);
        return id ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/avm_bus_arbiter_if.sv
// Bundle of the two requester ports and the shared Avalon-MM port.
// "master" is the arbiter's view; "slave" is the view of the
// pipelines and the UART that surround it.
interface avm_bus_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // Requester 0 (read pipeline)
    logic [ADDR_W-1:0] r0_address;
    logic              r0_read;
    logic              r0_write;
    logic [DATA_W-1:0] r0_writedata;
    logic              r0_waitrequest;
    logic              r0_readdatavalid;
    logic [DATA_W-1:0] r0_readdata;

    // Requester 1 (write pipeline)
    logic [ADDR_W-1:0] r1_address;
    logic              r1_read;
    logic              r1_write;
    logic [DATA_W-1:0] r1_writedata;
    logic              r1_waitrequest;
    logic              r1_readdatavalid;
    logic [DATA_W-1:0] r1_readdata;

    // Shared port towards the UART
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        input  r0_address, r0_read, r0_write, r0_writedata,
        output r0_waitrequest, r0_readdatavalid, r0_readdata,
        input  r1_address, r1_read, r1_write, r1_writedata,
        output r1_waitrequest, r1_readdatavalid, r1_readdata,
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata
    );

    modport slave (
        output r0_address, r0_read, r0_write, r0_writedata,
        input  r0_waitrequest, r0_readdatavalid, r0_readdata,
        output r1_address, r1_read, r1_write, r1_writedata,
        input  r1_waitrequest, r1_readdatavalid, r1_readdata,
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdatavalid, avm_readdata
    );

endinterface

// File: rtl/avm_tag_fifo.sv
// Small FIFO of requester IDs, one entry per outstanding read.
// The head is visible combinationally so a response can be routed in
// the same cycle it arrives. Push and pop may coincide at any
// occupancy, including full (the popped slot is the one refilled).
module avm_tag_fifo
    import rsa_avm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  req_id_t din,
    output req_id_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t          mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Tag storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

    // Read/write pointers; reset discards every outstanding tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/avm_bus_arbiter.sv
// Shares the UART's Avalon-MM port between the read pipeline (req0)
// and the write pipeline (req1). Grants are registered and handed out
// round-robin; a grant is held until the command is accepted or the
// requester withdraws it. Read responses are steered back using the
// tag FIFO, which also limits the number of reads in flight.
module avm_bus_arbiter
    import rsa_avm_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    avm_bus_arbiter_if.master  bus,
    output logic               o_err
);

    arb_state_t        state_q, state_d;
    req_id_t           rr_q, rr_d;
    logic              err_q, err_d;

    logic              gnt_valid;
    req_id_t           gnt_id;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_writedata;
    logic              pend0;
    logic              pend1;
    logic              own_pend;
    logic              other_pend;
    logic              fwd_read;
    logic              fwd_write;
    logic              accept;
    logic              rsp_ok;

    logic              fifo_push;
    req_id_t           fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    assign pend0  = bus.r0_read | bus.r0_write;
    assign pend1  = bus.r1_read | bus.r1_write;
    assign rsp_ok = bus.avm_readdatavalid & ~fifo_empty;

    // Select the granted requester's command and decide what reaches the UART
    always_comb begin
        gnt_valid     = (state_q != IDLE);
        gnt_id        = (state_q == GNT1);
        sel_read      = gnt_id ? bus.r1_read      : bus.r0_read;
        sel_write     = gnt_id ? bus.r1_write     : bus.r0_write;
        sel_address   = gnt_id ? bus.r1_address   : bus.r0_address;
        sel_writedata = gnt_id ? bus.r1_writedata : bus.r0_writedata;
        own_pend      = gnt_id ? pend1 : pend0;
        other_pend    = gnt_id ? pend0 : pend1;
        // Write wins over a simultaneous read; a read needs a free tag
        // slot, which a response popping this cycle also provides.
        fwd_write     = gnt_valid & sel_write;
        fwd_read      = gnt_valid & sel_read & ~sel_write &
                        (~fifo_full | rsp_ok);
        accept        = (fwd_read | fwd_write) & ~bus.avm_waitrequest;
        fifo_push     = accept & fwd_read;
    end

    // Next grant, round-robin pointer and error detection
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        err_d   = err_q
                | (gnt_valid & sel_read & sel_write)
                | (bus.avm_readdatavalid & fifo_empty);
        case (state_q)
            IDLE: begin
                if (pend0 & pend1)  state_d = gnt_state(rr_q);
                else if (pend0)     state_d = GNT0;
                else if (pend1)     state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (accept) begin
                    rr_d = ~gnt_id;
                    if (other_pend)     state_d = gnt_state(~gnt_id);
                    else if (own_pend)  state_d = gnt_state(gnt_id);
                    else                state_d = IDLE;
                end else if (!own_pend) begin
                    // Command withdrawn before acceptance: release, keep rr
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, round-robin pointer and sticky error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    avm_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (fifo_push),
        .pop   (bus.avm_readdatavalid),
        .din   (gnt_id),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Shared port: zero whenever nothing is granted
    assign bus.avm_address   = gnt_valid ? sel_address   : '0;
    assign bus.avm_writedata = gnt_valid ? sel_writedata : '0;
    assign bus.avm_read      = fwd_read;
    assign bus.avm_write     = fwd_write;

    // Requester handshakes and response routing
    assign bus.r0_waitrequest   = ~(accept & (state_q == GNT0));
    assign bus.r1_waitrequest   = ~(accept & (state_q == GNT1));
    assign bus.r0_readdatavalid = rsp_ok & (fifo_head == 1'b0);
    assign bus.r1_readdatavalid = rsp_ok & (fifo_head == 1'b1);
    assign bus.r0_readdata      = bus.avm_readdata;
    assign bus.r1_readdata      = bus.avm_readdata;

    assign o_err = err_q;

endmodule

// File: tb/tb_avm_bus_arbiter.sv
// Randomised bench for avm_bus_arbiter. A transaction-level model
// (current grant owner, round-robin favourite, queue of outstanding
// read owners, sticky error) predicts every output each cycle.
module tb_avm_bus_arbiter;
    import rsa_avm_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    avm_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avm_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master),
        .o_err (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model state
    int  m_gnt = -1;      // -1 none, else owning requester
    int  m_rr  = 0;       // favoured requester when both ask
    int  m_q[$];          // owners of outstanding reads, oldest first
    bit  m_err = 1'b0;
    bit  m_acc[2];

    // Stimulus for the current cycle
    bit          s_rd[2];
    bit          s_wr[2];
    logic [4:0]  s_ad[2];
    logic [31:0] s_wd[2];
    bit          s_aw;
    bit          s_av;
    logic [31:0] s_ard;

    logic [4:0] addr_tab[4];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        bus.r0_read           = s_rd[0];
        bus.r0_write          = s_wr[0];
        bus.r0_address        = s_ad[0];
        bus.r0_writedata      = s_wd[0];
        bus.r1_read           = s_rd[1];
        bus.r1_write          = s_wr[1];
        bus.r1_address        = s_ad[1];
        bus.r1_writedata      = s_wd[1];
        bus.avm_waitrequest   = s_aw;
        bus.avm_readdatavalid = s_av;
        bus.avm_readdata      = s_ard;
    endtask

    // Predict outputs for the applied inputs, compare, then advance the model
    task automatic eval_cycle(input bit advance);
        int n;
        bit pend[2];
        bit crd, cwr, fwd, acc, popv, full;
        logic [4:0]  e_ad;
        logic [31:0] e_wd;
        n    = m_gnt;
        popv = s_av && (m_q.size() > 0);
        full = (m_q.size() >= MAX_OUT);
        crd = 0; cwr = 0; fwd = 0; e_ad = '0; e_wd = '0;
        if (n >= 0) begin
            crd  = s_rd[n] && !s_wr[n];
            cwr  = s_wr[n];
            fwd  = crd && (!full || popv);
            e_ad = s_ad[n];
            e_wd = s_wd[n];
        end
        acc = (fwd || cwr) && !s_aw;

        check_eq("avm_read",      bus.avm_read,       fwd);
        check_eq("avm_write",     bus.avm_write,      cwr);
        check_eq("avm_address",   bus.avm_address,    e_ad);
        check_eq("avm_writedata", bus.avm_writedata,  e_wd);
        check_eq("r0_wait",       bus.r0_waitrequest, !(acc && n == 0));
        check_eq("r1_wait",       bus.r1_waitrequest, !(acc && n == 1));
        check_eq("r0_rdv",        bus.r0_readdatavalid, popv && m_q[0] == 0);
        check_eq("r1_rdv",        bus.r1_readdatavalid, popv && m_q[0] == 1);
        check_eq("r0_rdata",      bus.r0_readdata,    s_ard);
        check_eq("r1_rdata",      bus.r1_readdata,    s_ard);
        check_eq("o_err",         err,                m_err);

        if (!advance) return;

        pend[0] = s_rd[0] | s_wr[0];
        pend[1] = s_rd[1] | s_wr[1];
        m_acc[0] = 0;
        m_acc[1] = 0;
        if (s_av) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (n >= 0) begin
            if (s_rd[n] && s_wr[n]) m_err = 1'b1;
            if (acc) begin
                txn++;
                $display("txn %0d: req%0d %s addr=%0h wdata=%0h", txn, n,
                         fwd ? "read " : "write", e_ad, e_wd);
                m_acc[n] = 1;
                if (fwd) m_q.push_back(n);
                m_rr = 1 - n;
                if (pend[1-n])     m_gnt = 1 - n;
                else if (!pend[n]) m_gnt = -1;
            end else if (!pend[n]) begin
                m_gnt = -1;
            end
        end else begin
            if (pend[0] && pend[1]) m_gnt = m_rr;
            else if (pend[0])       m_gnt = 0;
            else if (pend[1])       m_gnt = 1;
        end
    endtask

    // Requesters mostly hold an unaccepted command; new commands are random
    task automatic gen_inputs(input int p_req, input int p_both, input int p_wait,
                              input int p_rdv, input int p_stray, input int p_rd);
        for (int k = 0; k < 2; k++) begin
            bit active;
            active = s_rd[k] | s_wr[k];
            if (active && !m_acc[k] && $urandom_range(99) < 90) begin
                // keep the same command
            end else if ($urandom_range(99) < p_req) begin
                if ($urandom_range(99) < p_both) begin
                    s_rd[k] = 1; s_wr[k] = 1;
                end else if ($urandom_range(99) < p_rd) begin
                    s_rd[k] = 1; s_wr[k] = 0;
                end else begin
                    s_rd[k] = 0; s_wr[k] = 1;
                end
                s_ad[k] = ($urandom_range(3) == 3) ? 5'($urandom) : addr_tab[$urandom_range(2)];
                s_wd[k] = $urandom;
            end else begin
                s_rd[k] = 0; s_wr[k] = 0;
            end
        end
        s_aw  = ($urandom_range(99) < p_wait);
        s_av  = (m_q.size() > 0) ? ($urandom_range(99) < p_rdv)
                                 : ($urandom_range(99) < p_stray);
        s_ard = $urandom;
    endtask

    task automatic run_phase(input int cycles, input int p_req, input int p_both,
                             input int p_wait, input int p_rdv, input int p_stray,
                             input int p_rd);
        for (int c = 0; c < cycles; c++) begin
            gen_inputs(p_req, p_both, p_wait, p_rdv, p_stray, p_rd);
            drive_bus();
            #1;
            eval_cycle(1'b1);
            @(negedge clk);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            s_rd[k] = 0; s_wr[k] = 0; s_ad[k] = '0; s_wd[k] = '0;
            m_acc[k] = 0;
        end
        s_aw = 0; s_av = 0; s_ard = '0;
    endtask

    initial begin
        int guard;
        addr_tab[0] = RX_ADDR;
        addr_tab[1] = TX_ADDR;
        addr_tab[2] = STATUS_ADDR;
        addr_tab[3] = 5'd12;

        // Reset values while reset is held
        clear_inputs();
        drive_bus();
        @(negedge clk);
        #1;
        eval_cycle(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Mixed traffic, no protocol errors
        run_phase(300, 60, 0, 30, 40, 0, 50);
        // Contention: both always requesting, no wait states
        run_phase(60, 100, 0, 0, 100, 0, 50);
        // Read-heavy with rare responses: fills the tag FIFO
        run_phase(200, 90, 0, 10, 8, 0, 90);

        // Reach a state with a live grant and at least 2 reads outstanding
        guard = 0;
        while (!(m_q.size() >= 2 && m_gnt >= 0) && guard < 500) begin
            run_phase(1, 90, 0, 10, 5, 0, 90);
            guard++;
        end
        check_eq("reset_setup_reached", (guard < 500), 1'b1);

        // Asynchronous reset mid-grant, away from any clock edge
        s_rd[0] = 1; s_wr[0] = 0; s_rd[1] = 1; s_wr[1] = 0;
        s_aw = 1; s_av = 0;
        drive_bus();
        #2;
        rst = 1'b1;
        #1;
        m_gnt = -1; m_rr = 0; m_q.delete(); m_err = 1'b0;
        eval_cycle(1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0;

        // Both requesting straight after reset: req0 must win first
        run_phase(20, 100, 0, 0, 100, 0, 50);

        // Stray response with nothing outstanding
        clear_inputs();
        guard = 0;
        while (m_q.size() > 0 && guard < 50) begin
            s_av = 1; drive_bus(); #1; eval_cycle(1'b1); @(negedge clk);
            s_av = 0; guard++;
        end
        clear_inputs();
        s_av = 1; s_ard = 32'hDEAD_BEEF;
        drive_bus(); #1; eval_cycle(1'b1); @(negedge clk);
        clear_inputs();
        drive_bus(); #1; eval_cycle(1'b1); @(negedge clk);
        check_eq("err_after_stray", err, 1'b1);

        // Random traffic including read+write together and stray responses
        run_phase(300, 60, 8, 25, 40, 5, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
